// File: rtl/mic_dma_pkg.sv
// Shared types and constants for the microphone ring DMA engine.
// Contents:
//   state_e          - engine FSM states
//   BYTES_PER_WORD   - byte count of the default 32-bit sample word
//   MIN_BUF_WORDS    - smallest ring length the engine will run with
//   bytes_per_word() - byte count for an arbitrary sample width
package mic_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitFrame,
    StSel,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 32 / 8;
  localparam int unsigned MIN_BUF_WORDS  = 2;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mic_dma_event_latch.sv
// Sticky event flag for the HPS.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   i_set   - event pulse; wins over a same-cycle ack so no event is lost
//   i_ack   - clears the flag when no set is present
//   o_q     - latched flag
module mic_dma_event_latch (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_ack,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_ack) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mic_ring_dma.sv
// Multi-channel microphone-to-SDRAM DMA master. On every frame strobe it steps the mic select
// mux through all channels and writes one word per channel over Avalon-MM into per-channel ring
// buffers, raising half/end latches for the HPS and flagging dropped (overrun) strobes.
// Ports:
//   CLK, RESET_N                 - clock, asynchronous active-low reset
//   AM_*                         - Avalon-MM write master (single-beat writes)
//   mic_data / select            - mic mux sample and select (channel + 1, 0 = idle)
//   frame_valid                  - one-cycle strobe: a new sample set is ready
//   start, continuous, base_addr,
//   buf_words                    - configuration, sampled only on the start rising edge
//   half_way_ack / end_ack       - clear the corresponding latch
//   half_way_latch, end_latch,
//   overrun, FINISHED            - status to the HPS
module mic_ring_dma
  import mic_dma_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CH_STRIDE = 7680000,
  parameter int unsigned SEL_W     = $clog2(NUM_CH) + 1
) (
  input  logic                CLK,
  input  logic                RESET_N,
  output logic [ADDR_W-1:0]   AM_ADDR,
  output logic [2:0]          AM_BURSTCOUNT,
  output logic                AM_WRITE,
  output logic [DATA_W-1:0]   AM_WRITEDATA,
  output logic [DATA_W/8-1:0] AM_BYTEENABLE,
  input  logic                AM_WAITREQUEST,
  input  logic [DATA_W-1:0]   mic_data,
  output logic [SEL_W-1:0]    select,
  input  logic                frame_valid,
  input  logic                start,
  input  logic                continuous,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [31:0]         buf_words,
  input  logic                half_way_ack,
  input  logic                end_ack,
  output logic                half_way_latch,
  output logic                end_latch,
  output logic                overrun,
  output logic                FINISHED
);

  localparam int unsigned BPW  = bytes_per_word(DATA_W);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e              r_state;
  logic                r_start_q;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_buf;
  logic                r_cont;
  logic [31:0]         r_wr_idx;
  logic [CH_W-1:0]     r_ch;
  logic [ADDR_W-1:0]   r_ch_addr [NUM_CH];
  logic                r_am_write;
  logic [ADDR_W-1:0]   r_am_addr;
  logic [DATA_W-1:0]   r_am_wdata;
  logic [SEL_W-1:0]    r_select;
  logic                r_finished;

  logic                w_start_edge;
  logic                w_last_ch;
  logic                w_frame_end;
  logic [31:0]         w_next_idx;
  logic                w_half_set;
  logic                w_end_set;
  logic                w_ovr_set;
  logic                w_ovr_clr;
  logic [ADDR_W-1:0]   w_reload [NUM_CH];

  // Channel ring bases; offsets are constants so each is a single add onto the latched base.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_reload
    localparam logic [ADDR_W-1:0] OFF = ADDR_W'(CH_STRIDE) * ADDR_W'(i);
    assign w_reload[i] = r_base + OFF;
  end

  assign w_start_edge = start && !r_start_q;
  assign w_last_ch    = (r_ch == LAST_CH);
  // AM_WRITE is always high in StWrite, so a low waitrequest here is an accept.
  assign w_frame_end  = (r_state == StWrite) && !AM_WAITREQUEST && w_last_ch;
  assign w_next_idx   = r_wr_idx + 32'd1;
  assign w_half_set   = w_frame_end && (w_next_idx == (r_buf >> 1));
  assign w_end_set    = w_frame_end && (w_next_idx == r_buf);
  assign w_ovr_set    = frame_valid &&
                        ((r_state == StArm) || (r_state == StSel) || (r_state == StWrite));
  assign w_ovr_clr    = (r_state == StIdle) && w_start_edge;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= StIdle;
      r_start_q  <= 1'b0;
      r_base     <= '0;
      r_buf      <= '0;
      r_cont     <= 1'b0;
      r_wr_idx   <= '0;
      r_ch       <= '0;
      r_am_write <= 1'b0;
      r_am_addr  <= '0;
      r_am_wdata <= '0;
      r_select   <= '0;
      r_finished <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch_addr[i] <= '0;
      end
    end else begin
      r_start_q <= start;
      unique case (r_state)
        StIdle: begin
          r_select   <= '0;
          r_finished <= 1'b0;
          r_am_write <= 1'b0;
          if (w_start_edge) begin
            r_base  <= base_addr;
            r_buf   <= (buf_words < 32'(MIN_BUF_WORDS)) ? 32'(MIN_BUF_WORDS) : buf_words;
            r_cont  <= continuous;
            r_state <= StArm;
          end
        end
        StArm: begin
          r_wr_idx <= '0;
          r_ch     <= '0;
          for (int i = 0; i < NUM_CH; i++) begin
            r_ch_addr[i] <= w_reload[i];
          end
          r_state <= StWaitFrame;
        end
        StWaitFrame: begin
          if (!start) begin
            r_state <= StIdle;
          end else if (frame_valid) begin
            r_ch     <= '0;
            r_select <= SEL_W'(1);
            r_state  <= StSel;
          end
        end
        StSel: begin
          // mic_data has settled for the select driven since the start of this cycle.
          r_am_wdata <= mic_data;
          r_am_addr  <= r_ch_addr[r_ch];
          r_am_write <= 1'b1;
          r_state    <= StWrite;
        end
        StWrite: begin
          if (!AM_WAITREQUEST) begin
            r_am_write      <= 1'b0;
            r_ch_addr[r_ch] <= r_ch_addr[r_ch] + ADDR_W'(BPW);
            if (!w_last_ch) begin
              r_ch     <= r_ch + CH_W'(1);
              r_select <= SEL_W'(r_ch) + SEL_W'(2);
              r_state  <= StSel;
            end else begin
              r_select <= '0;
              if (w_next_idx == r_buf) begin
                if (r_cont) begin
                  // Wrap: this reload overrides the per-channel increment above.
                  r_wr_idx <= '0;
                  for (int i = 0; i < NUM_CH; i++) begin
                    r_ch_addr[i] <= w_reload[i];
                  end
                  r_state <= StWaitFrame;
                end else begin
                  r_wr_idx   <= w_next_idx;
                  r_finished <= 1'b1;
                  r_state    <= StDone;
                end
              end else begin
                r_wr_idx <= w_next_idx;
                r_state  <= StWaitFrame;
              end
            end
          end
        end
        StDone: begin
          r_select <= '0;
          if (!start) begin
            r_finished <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  mic_dma_event_latch u_half_latch (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_set   (w_half_set),
    .i_ack   (half_way_ack),
    .o_q     (half_way_latch)
  );

  mic_dma_event_latch u_end_latch (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_set   (w_end_set),
    .i_ack   (end_ack),
    .o_q     (end_latch)
  );

  mic_dma_event_latch u_ovr_latch (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_set   (w_ovr_set),
    .i_ack   (w_ovr_clr),
    .o_q     (overrun)
  );

  assign AM_ADDR       = r_am_addr;
  assign AM_WRITE      = r_am_write;
  assign AM_WRITEDATA  = r_am_wdata;
  assign AM_BURSTCOUNT = {2'b00, r_am_write};
  assign AM_BYTEENABLE = {(DATA_W / 8){r_am_write}};
  assign select        = r_select;
  assign FINISHED      = r_finished;

endmodule
